// File: rtl/calendar_pkg.sv
// rtl/calendar_pkg.sv - weekday/month-length constants and leap-year helpers
package calendar_pkg;

   localparam logic [2:0] MON = 3'd0;
   localparam logic [2:0] TUE = 3'd1;
   localparam logic [2:0] WED = 3'd2;
   localparam logic [2:0] THU = 3'd3;
   localparam logic [2:0] FRI = 3'd4;
   localparam logic [2:0] SAT = 3'd5;
   localparam logic [2:0] SUN = 3'd6;

   localparam logic [4:0] DAYS_LONG     = 5'd31;
   localparam logic [4:0] DAYS_SHORT    = 5'd30;
   localparam logic [4:0] DAYS_FEB      = 5'd28;
   localparam logic [4:0] DAYS_FEB_LEAP = 5'd29;

   function automatic logic is_leap(input logic [31:0] year);
      return (year % 32'd4 == 32'd0) &&
             ((year % 32'd100 != 32'd0) || (year % 32'd400 == 32'd0));
   endfunction

   // An illegal month yields 0 so any day compared against it is rejected.
   function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic leap);
      case (month)
         4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: return DAYS_LONG;
         4'd4, 4'd6, 4'd9, 4'd11:                    return DAYS_SHORT;
         4'd2:                                       return leap ? DAYS_FEB_LEAP : DAYS_FEB;
         default:                                    return 5'd0;
      endcase
   endfunction

endpackage

// File: rtl/calendar_month_len.sv
// rtl/calendar_month_len.sv - combinational (month, year) -> (days in month, leap flag)
module calendar_month_len
   import calendar_pkg::*;
#(
   parameter int YEAR_W = 14
) (
   input  logic [3:0]        month_i,
   input  logic [YEAR_W-1:0] year_i,
   output logic [4:0]        days_o,
   output logic              leap_o
);

   assign leap_o = is_leap(32'(year_i));
   assign days_o = days_in_month(month_i, leap_o);

endmodule

// File: rtl/calendar_gregorian.sv
// rtl/calendar_gregorian.sv - Gregorian day/month/year/weekday register with strobed updates
module calendar_gregorian
   import calendar_pkg::*;
#(
   parameter int DEFAULT_DAY   = 1,
   parameter int DEFAULT_MONTH = 9,
   parameter int DEFAULT_YEAR  = 2023,
   parameter int DEFAULT_DOW   = 4,
   parameter int YEAR_MIN      = 2000,
   parameter int YEAR_MAX      = 2099,
   parameter int YEAR_W        = 14
) (
   input  logic              clk_100MHz,
   input  logic              reset,
   input  logic              end_of_day,
   input  logic              inc_day,
   input  logic              dec_day,
   input  logic              inc_month,
   input  logic              inc_year,
   input  logic              load,
   input  logic [4:0]        load_day,
   input  logic [3:0]        load_month,
   input  logic [YEAR_W-1:0] load_year,
   input  logic [2:0]        load_dow,
   output logic [4:0]        day,
   output logic [3:0]        month,
   output logic [YEAR_W-1:0] year,
   output logic [2:0]        dow,
   output logic              leap_year,
   output logic              end_of_year,
   output logic              load_err
);

   localparam bit PARAMS_OK =
      (YEAR_W >= 1) && (YEAR_W <= 31) && (YEAR_MIN >= 0) && (YEAR_MIN <= YEAR_MAX) &&
      (YEAR_MAX < (1 << YEAR_W)) &&
      (DEFAULT_YEAR >= YEAR_MIN) && (DEFAULT_YEAR <= YEAR_MAX) &&
      (DEFAULT_MONTH >= 1) && (DEFAULT_MONTH <= 12) && (DEFAULT_DAY >= 1) &&
      (DEFAULT_DAY <= int'(days_in_month(4'(DEFAULT_MONTH), is_leap(32'(DEFAULT_YEAR))))) &&
      (DEFAULT_DOW >= 0) && (DEFAULT_DOW <= 6);

   generate
      if (!PARAMS_OK) begin : g_bad_params
         $error("calendar_gregorian: illegal DEFAULT_*/YEAR_* parameter combination");
      end
   endgenerate

   localparam logic [YEAR_W-1:0] Y_MIN = YEAR_W'(YEAR_MIN);
   localparam logic [YEAR_W-1:0] Y_MAX = YEAR_W'(YEAR_MAX);

   logic [4:0]        day_q, day_d;
   logic [3:0]        month_q, month_d;
   logic [YEAR_W-1:0] year_q, year_d;
   logic [2:0]        dow_q, dow_d;
   logic              eoy_q, eoy_d;
   logic              load_err_q, load_err_d;

   logic [4:0]        cur_days, ld_days, prev_len, next_len;
   logic              cur_leap, ld_leap_unused, next_year_leap, load_ok;
   logic [3:0]        next_month, prev_month;
   logic [YEAR_W-1:0] next_year, prev_year;

   calendar_month_len #(.YEAR_W(YEAR_W)) u_cur_len (
      .month_i (month_q),
      .year_i  (year_q),
      .days_o  (cur_days),
      .leap_o  (cur_leap)
   );

   calendar_month_len #(.YEAR_W(YEAR_W)) u_load_len (
      .month_i (load_month),
      .year_i  (load_year),
      .days_o  (ld_days),
      .leap_o  (ld_leap_unused)
   );

   // Neighbouring months share the current year's leap flag: only February cares,
   // and its neighbours never cross a year boundary.
   always_comb begin
      next_month     = (month_q == 4'd12) ? 4'd1 : month_q + 4'd1;
      prev_month     = (month_q == 4'd1) ? 4'd12 : month_q - 4'd1;
      next_year      = (year_q == Y_MAX) ? Y_MIN : year_q + YEAR_W'(1);
      prev_year      = (year_q == Y_MIN) ? Y_MAX : year_q - YEAR_W'(1);
      next_len       = days_in_month(next_month, cur_leap);
      prev_len       = days_in_month(prev_month, cur_leap);
      next_year_leap = is_leap(32'(next_year));
      load_ok        = (load_month >= 4'd1) && (load_month <= 4'd12) &&
                       (load_day != 5'd0) && (load_day <= ld_days) &&
                       (load_year >= Y_MIN) && (load_year <= Y_MAX) && (load_dow <= SUN);

      day_d      = day_q;
      month_d    = month_q;
      year_d     = year_q;
      dow_d      = dow_q;
      eoy_d      = 1'b0;
      load_err_d = 1'b0;

      if (load) begin
         if (load_ok) begin
            day_d   = load_day;
            month_d = load_month;
            year_d  = load_year;
            dow_d   = load_dow;
         end else begin
            load_err_d = 1'b1;
         end
      end else if (end_of_day || inc_day) begin
         dow_d = (dow_q == SUN) ? MON : dow_q + 3'd1;
         if (day_q < cur_days) begin
            day_d = day_q + 5'd1;
         end else begin
            day_d   = 5'd1;
            month_d = next_month;
            if (month_q == 4'd12) begin
               year_d = next_year;
               eoy_d  = 1'b1;
            end
         end
      end else if (dec_day) begin
         dow_d = (dow_q == MON) ? SUN : dow_q - 3'd1;
         if (day_q > 5'd1) begin
            day_d = day_q - 5'd1;
         end else begin
            day_d   = prev_len;
            month_d = prev_month;
            if (month_q == 4'd1) begin
               year_d = prev_year;
            end
         end
      end else if (inc_month) begin
         month_d = next_month;
         if (day_q > next_len) begin
            day_d = next_len;
         end
      end else if (inc_year) begin
         year_d = next_year;
         if ((month_q == 4'd2) && (day_q == DAYS_FEB_LEAP) && !next_year_leap) begin
            day_d = DAYS_FEB;
         end
      end
   end

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         day_q   <= 5'(DEFAULT_DAY);
         month_q <= 4'(DEFAULT_MONTH);
         year_q  <= YEAR_W'(DEFAULT_YEAR);
         dow_q   <= 3'(DEFAULT_DOW);
      end else begin
         day_q   <= day_d;
         month_q <= month_d;
         year_q  <= year_d;
         dow_q   <= dow_d;
      end
   end

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         eoy_q      <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         eoy_q      <= eoy_d;
         load_err_q <= load_err_d;
      end
   end

   assign day         = day_q;
   assign month       = month_q;
   assign year        = year_q;
   assign dow         = dow_q;
   assign leap_year   = cur_leap;
   assign end_of_year = eoy_q;
   assign load_err    = load_err_q;

endmodule

// File: tb/tb_calendar_gregorian.sv
// tb/tb_calendar_gregorian.sv - directed and randomized checks against a day-serial calendar model
module tb_calendar_gregorian;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        end_of_day = 1'b0, inc_day = 1'b0, dec_day = 1'b0;
   logic        inc_month = 1'b0, inc_year = 1'b0, load = 1'b0;
   logic [4:0]  load_day = '0;
   logic [3:0]  load_month = '0;
   logic [13:0] load_year = '0;
   logic [2:0]  load_dow = '0;
   logic [4:0]  day;
   logic [3:0]  month;
   logic [13:0] year;
   logic [2:0]  dow;
   logic        leap_year, end_of_year, load_err;

   int n_vec = 0;
   int n_err = 0;

   int m_day, m_mon, m_year, m_dow;
   bit m_eoy, m_err;

   always #5 clk = ~clk;

   calendar_gregorian dut (
      .clk_100MHz (clk),
      .reset      (reset),
      .end_of_day (end_of_day),
      .inc_day    (inc_day),
      .dec_day    (dec_day),
      .inc_month  (inc_month),
      .inc_year   (inc_year),
      .load       (load),
      .load_day   (load_day),
      .load_month (load_month),
      .load_year  (load_year),
      .load_dow   (load_dow),
      .day        (day),
      .month      (month),
      .year       (year),
      .dow        (dow),
      .leap_year  (leap_year),
      .end_of_year(end_of_year),
      .load_err   (load_err)
   );

   function automatic bit ref_leap(input int y);
      return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
   endfunction

   function automatic int ref_dim(input int m, input int y);
      if (m == 2) return ref_leap(y) ? 29 : 28;
      if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
      if (m >= 1 && m <= 12) return 31;
      return 0;
   endfunction

   // Dates are modelled as a day count from 2000-01-01 over the 2000..2099 window.
   function automatic int to_serial(input int d, input int m, input int y);
      int s = 0;
      for (int yy = 2000; yy < y; yy++) s += ref_leap(yy) ? 366 : 365;
      for (int mm = 1; mm < m; mm++) s += ref_dim(mm, y);
      return s + d - 1;
   endfunction

   localparam int TOTAL_DAYS = 36525;

   task automatic from_serial(input int s);
      int r = s;
      m_year = 2000;
      while (r >= (ref_leap(m_year) ? 366 : 365)) begin
         r -= ref_leap(m_year) ? 366 : 365;
         m_year++;
      end
      m_mon = 1;
      while (r >= ref_dim(m_mon, m_year)) begin
         r -= ref_dim(m_mon, m_year);
         m_mon++;
      end
      m_day = r + 1;
   endtask

   task automatic model_step(input bit rst, input bit ld, input bit eod, input bit incd,
                             input bit decd, input bit incm, input bit incy,
                             input int ld_d, input int ld_m, input int ld_y, input int ld_w);
      m_eoy = 0;
      m_err = 0;
      if (rst) begin
         m_day = 1; m_mon = 9; m_year = 2023; m_dow = 4;
      end else if (ld) begin
         if (ld_m >= 1 && ld_m <= 12 && ld_d >= 1 && ld_d <= ref_dim(ld_m, ld_y) &&
             ld_y >= 2000 && ld_y <= 2099 && ld_w <= 6) begin
            m_day = ld_d; m_mon = ld_m; m_year = ld_y; m_dow = ld_w;
         end else begin
            m_err = 1;
         end
      end else if (eod || incd) begin
         from_serial((to_serial(m_day, m_mon, m_year) + 1) % TOTAL_DAYS);
         m_dow = (m_dow + 1) % 7;
         m_eoy = (m_day == 1) && (m_mon == 1);
      end else if (decd) begin
         from_serial((to_serial(m_day, m_mon, m_year) + TOTAL_DAYS - 1) % TOTAL_DAYS);
         m_dow = (m_dow + 6) % 7;
      end else if (incm) begin
         m_mon = (m_mon % 12) + 1;
         if (m_day > ref_dim(m_mon, m_year)) m_day = ref_dim(m_mon, m_year);
      end else if (incy) begin
         m_year = (m_year == 2099) ? 2000 : m_year + 1;
         if (m_day > ref_dim(m_mon, m_year)) m_day = ref_dim(m_mon, m_year);
      end
   endtask

   task automatic apply(input bit rst, input bit ld, input bit eod, input bit incd,
                        input bit decd, input bit incm, input bit incy,
                        input int ld_d, input int ld_m, input int ld_y, input int ld_w);
      reset = rst; load = ld; end_of_day = eod; inc_day = incd; dec_day = decd;
      inc_month = incm; inc_year = incy;
      load_day = 5'(ld_d); load_month = 4'(ld_m); load_year = 14'(ld_y); load_dow = 3'(ld_w);
      model_step(rst, ld, eod, incd, decd, incm, incy,
                 int'(load_day), int'(load_month), int'(load_year), int'(load_dow));
      @(posedge clk);
      #1;
      reset = 0; load = 0; end_of_day = 0; inc_day = 0; dec_day = 0; inc_month = 0; inc_year = 0;
   endtask

   task automatic do_load(input int d, input int m, input int y, input int w);
      apply(0, 1, 0, 0, 0, 0, 0, d, m, y, w);
   endtask

   function automatic logic [28:0] pack(input int d, input int m, input int y, input int w,
                                        input bit lp, input bit eo, input bit er);
      return {5'(d), 4'(m), 14'(y), 3'(w), lp, eo, er};
   endfunction

   function automatic logic [28:0] obs();
      return {day, month, year, dow, leap_year, end_of_year, load_err};
   endfunction

   function automatic string fmt(input logic [28:0] v);
      return $sformatf("%0d-%0d-%0d dow=%0d leap=%0b eoy=%0b err=%0b",
                       v[19:6], v[23:20], v[28:24], v[5:3], v[2], v[1], v[0]);
   endfunction

   task automatic test_reset();
      logic [28:0] want;
      apply(1, 1, 1, 1, 1, 1, 1, 15, 6, 2050, 2);
      want = pack(1, 9, 2023, 4, 0, 0, 0);
      n_vec++;
      if (obs() !== want) begin
         n_err++;
         $display("FAIL reset_over_load: got %s want %s", fmt(obs()), fmt(want));
      end
   endtask

   task automatic test_leap_rollover();
      logic [28:0] want;
      do_load(28, 2, 2024, 2);
      apply(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      want = pack(29, 2, 2024, 3, 1, 0, 0);
      n_vec++;
      if (obs() !== want) begin
         n_err++;
         $display("FAIL leap_feb29: got %s want %s", fmt(obs()), fmt(want));
      end
      apply(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      want = pack(1, 3, 2024, 4, 1, 0, 0);
      n_vec++;
      if (obs() !== want) begin
         n_err++;
         $display("FAIL leap_mar01: got %s want %s", fmt(obs()), fmt(want));
      end
   endtask

   task automatic test_year_wrap();
      logic [28:0] want;
      do_load(31, 12, 2099, 3);
      apply(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      want = pack(1, 1, 2000, 4, 1, 1, 0);
      n_vec++;
      if (obs() !== want) begin
         n_err++;
         $display("FAIL year_wrap: got %s want %s", fmt(obs()), fmt(want));
      end
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      want = pack(1, 1, 2000, 4, 1, 0, 0);
      n_vec++;
      if (obs() !== want) begin
         n_err++;
         $display("FAIL eoy_one_cycle: got %s want %s", fmt(obs()), fmt(want));
      end
   endtask

   task automatic test_clamp();
      logic [28:0] want;
      do_load(31, 1, 2023, 1);
      apply(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      want = pack(28, 2, 2023, 1, 0, 0, 0);
      n_vec++;
      if (obs() !== want) begin
         n_err++;
         $display("FAIL inc_month_clamp: got %s want %s", fmt(obs()), fmt(want));
      end
      do_load(29, 2, 2024, 3);
      apply(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      want = pack(28, 2, 2025, 3, 0, 0, 0);
      n_vec++;
      if (obs() !== want) begin
         n_err++;
         $display("FAIL inc_year_clamp: got %s want %s", fmt(obs()), fmt(want));
      end
      do_load(15, 12, 2030, 0);
      apply(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      want = pack(15, 1, 2030, 0, 0, 0, 0);
      n_vec++;
      if (obs() !== want) begin
         n_err++;
         $display("FAIL inc_month_wrap: got %s want %s", fmt(obs()), fmt(want));
      end
   endtask

   task automatic test_load_err();
      logic [28:0] want;
      int bad [8][4] = '{'{29, 2, 2023, 3}, '{0, 5, 2030, 1}, '{31, 4, 2030, 1},
                         '{10, 13, 2030, 1}, '{10, 0, 2030, 1}, '{10, 5, 1999, 1},
                         '{10, 5, 2100, 1}, '{10, 5, 2030, 7}};
      do_load(15, 7, 2031, 2);
      for (int i = 0; i < 8; i++) begin
         do_load(bad[i][0], bad[i][1], bad[i][2], bad[i][3]);
         want = pack(15, 7, 2031, 2, 0, 0, 1);
         n_vec++;
         if (obs() !== want) begin
            n_err++;
            $display("FAIL load_reject_%0d: got %s want %s", i, fmt(obs()), fmt(want));
         end
      end
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      want = pack(15, 7, 2031, 2, 0, 0, 0);
      n_vec++;
      if (obs() !== want) begin
         n_err++;
         $display("FAIL load_err_one_cycle: got %s want %s", fmt(obs()), fmt(want));
      end
      do_load(29, 2, 2024, 3);
      want = pack(29, 2, 2024, 3, 1, 0, 0);
      n_vec++;
      if (obs() !== want) begin
         n_err++;
         $display("FAIL load_accept: got %s want %s", fmt(obs()), fmt(want));
      end
   endtask

   task automatic test_priority();
      logic [28:0] want;
      do_load(1, 9, 2023, 4);
      apply(0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0);
      want = pack(2, 9, 2023, 5, 0, 0, 0);
      n_vec++;
      if (obs() !== want) begin
         n_err++;
         $display("FAIL advance_priority: got %s want %s", fmt(obs()), fmt(want));
      end
      do_load(1, 1, 2000, 5);
      apply(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
      want = pack(31, 12, 2099, 4, 0, 0, 0);
      n_vec++;
      if (obs() !== want) begin
         n_err++;
         $display("FAIL dec_year_wrap: got %s want %s", fmt(obs()), fmt(want));
      end
      apply(0, 1, 1, 1, 1, 1, 1, 10, 10, 2030, 6);
      want = pack(10, 10, 2030, 6, 0, 0, 0);
      n_vec++;
      if (obs() !== want) begin
         n_err++;
         $display("FAIL load_priority: got %s want %s", fmt(obs()), fmt(want));
      end
      apply(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
      want = pack(10, 11, 2030, 6, 0, 0, 0);
      n_vec++;
      if (obs() !== want) begin
         n_err++;
         $display("FAIL month_over_year: got %s want %s", fmt(obs()), fmt(want));
      end
   endtask

   task automatic test_random();
      logic [28:0] want;
      int edge_dates [6][3] = '{'{31, 12, 2099}, '{1, 1, 2000}, '{29, 2, 2096},
                                '{31, 1, 2023}, '{28, 2, 2023}, '{1, 3, 2024}};
      int r, k;
      for (int i = 0; i < 4000; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 2) begin
            apply(1, ($urandom_range(0, 1) == 1), 1, 0, 0, 0, 0, 5, 5, 2040, 1);
         end else if (r < 8) begin
            apply(0, 1, ($urandom_range(0, 1) == 1), 0, 0, 0, 0,
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 15)),
                  int'($urandom_range(1990, 2110)), int'($urandom_range(0, 7)));
         end else if (r < 12) begin
            k = int'($urandom_range(0, 5));
            do_load(edge_dates[k][0], edge_dates[k][1], edge_dates[k][2],
                    int'($urandom_range(0, 6)));
         end else begin
            apply(0, 0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 5) == 0), 0, 0, 0, 0);
         end
         want = pack(m_day, m_mon, m_year, m_dow, ref_leap(m_year), m_eoy, m_err);
         n_vec++;
         if (obs() !== want) begin
            n_err++;
            $display("FAIL random_%0d: got %s want %s", i, fmt(obs()), fmt(want));
         end
      end
   endtask

   initial begin
      test_reset();
      test_leap_rollover();
      test_year_wrap();
      test_clamp();
      test_load_err();
      test_priority();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/calendar_gregorian.md
CALENDAR_GREGORIAN -- requirements
Module: calendar_gregorian

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DEFAULT_DAY, 1, day after reset.
- DEFAULT_MONTH, 9, month after reset.
- DEFAULT_YEAR, 2023, full year after reset.
- DEFAULT_DOW, 4, weekday after reset (0=Mon..6=Sun; 2023-09-01 is Friday).
- YEAR_MIN, 2000, lowest year held.
- YEAR_MAX, 2099, highest year held.
- YEAR_W, 14, year width in bits (covers 0..9999).
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk_100MHz, in, 1, system clock; all logic is on its rising edge.
- reset, in, 1, synchronous, active-high reset.
- end_of_day, in, 1, one-cycle strobe from the clock module.
- inc_day, in, 1, one-cycle debounced strobe: day +1.
- dec_day, in, 1, one-cycle debounced strobe: day -1.
- inc_month, in, 1, one-cycle strobe: month +1.
- inc_year, in, 1, one-cycle strobe: year +1.
- load, in, 1, one-cycle strobe: write the load_* date.
- load_day, in, 5, date to load: day.
- load_month, in, 4, date to load: month.
- load_year, in, YEAR_W, date to load: year.
- load_dow, in, 3, date to load: weekday.
- day, out, 5, current day, 1..31.
- month, out, 4, current month, 1..12.
- year, out, YEAR_W, current year, YEAR_MIN..YEAR_MAX.
- dow, out, 3, current weekday, 0..6.
- leap_year, out, 1, combinational leap flag for the current year.
- end_of_year, out, 1, one-cycle pulse on a 31/12 -> 01/01 rollover.
- load_err, out, 1, one-cycle pulse when a load is rejected.

Function
REQ-003 All state changes occur on the rising edge of clk_100MHz; the updated value is visible in the cycle after the strobe is sampled (latency 1).
REQ-004 At most one action is taken per cycle. Priority: reset > load > end_of_day > inc_day > dec_day > inc_month > inc_year. Lower-priority strobes in the same cycle are discarded.
REQ-005 leap_year is 1 when year is divisible by 4 and either not divisible by 100 or divisible by 400.
REQ-006 Days in month: 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11; month 2 is 29 if leap_year, else 28.
REQ-007 Advance (end_of_day or inc_day):
- If day < days-in-month: day+1.
- Else: day=1 and month+1.
- From month 12: month=1 and year+1.
- From YEAR_MAX: year wraps to YEAR_MIN.
REQ-008 Retreat (dec_day):
- If day > 1: day-1.
- Else: day = last day of the previous month, month-1.
- From month 1: month=12 and year-1.
- From YEAR_MIN: year wraps to YEAR_MAX.
REQ-009 dow increments mod 7 on every advance and decrements mod 7 on every retreat. inc_month and inc_year leave dow unchanged.
REQ-010 inc_month: month+1, 12 wraps to 1 with year unchanged. If day then exceeds the new month length, day is clamped to the last day in the same cycle.
REQ-011 inc_year: year+1, YEAR_MAX wraps to YEAR_MIN. A 29/02 date in a non-leap target year is clamped to 28/02.
REQ-012 load is accepted only when all of the following hold: 1<=load_month<=12; 1<=load_day<=days-in-month(load_month, load_year); YEAR_MIN<=load_year<=YEAR_MAX; load_dow<=6.
- Accepted: all four registers are written.
- Rejected: state is unchanged and load_err pulses for 1 cycle.
REQ-013 end_of_year is registered and asserted in the same cycle the 01/01 value first appears. It is triggered by end_of_day or inc_day only; dec_day, inc_month and inc_year never assert it.
REQ-014 Outputs never hold values outside their legal ranges, for any input sequence.

Reset
REQ-015 reset sets day, month, year and dow to their DEFAULT_* parameters and clears end_of_year and load_err, taking effect at the next clock edge.
REQ-016 reset overrides any strobe in the same cycle, including a load in progress.
REQ-017 Parameter legality: the DEFAULT_* date is valid and YEAR_MIN<=DEFAULT_YEAR<=YEAR_MAX. An illegal parameter combination is flagged at elaboration.

Structure
REQ-018 Package calendar_pkg holds:
- weekday constants MON..SUN;
- month-length constants;
- is_leap(year) function;
- days_in_month(month, leap) function.
REQ-019 One sub-module, calendar_month_len, is used twice: once for the current date and once for load validation. It is combinational, maps (month, year) to (days, leap), and contains no state.
REQ-020 The top level has a single always block for the date registers and a separate one for the pulse outputs.

Verification
REQ-021 2024-02-28 + end_of_day -> 2024-02-29, leap_year=1. A second end_of_day -> 2024-03-01, dow advanced by 2 in total.
REQ-022 2099-12-31 + end_of_day -> 2000-01-01, end_of_year=1 for exactly 1 cycle, leap_year=1 (2000 is divisible by 400).
REQ-023 2023-01-31 + inc_month -> 2023-02-28. 2024-02-29 + inc_year -> 2025-02-28, dow unchanged in both cases.
REQ-024 load 2023-02-29 -> load_err pulses 1 cycle, date unchanged. load 2024-02-29 dow=3 -> accepted, load_err=0.
REQ-025 end_of_day, inc_day and dec_day in one cycle at 2023-09-01 -> 2023-09-02 only. 2000-01-01 + dec_day -> 2099-12-31, end_of_year stays 0.
REQ-026 reset asserted together with load of 2050-06-15 -> 2023-09-01, dow=4, all pulses 0.
